// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types and constants for the SDRAM access arbiter.
//   arb_state_t : arbiter FSM states (IDLE, WR, RD)
//   DEF_AW      : default address width
//   DEF_DW      : default data width
//   STREAK_W    : width of the consecutive-write-grant counter
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int DEF_AW   = 25;
  localparam int DEF_DW   = 8;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } arb_state_t;

endpackage : sdram_arb_pkg

// File: rtl/sdram_arb_rdcache.sv
// -----------------------------------------------------------------------------
// sdram_arb_rdcache
// Single-entry read cache (tag, data, valid) for the SDRAM arbiter. Only
// instantiated when SDRAM_ARB_RDCACHE_EN is defined.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   dl_active     : download window; a rising edge invalidates the entry
//   lookup_addr   : address of the incoming read request
//   hit, hit_data : entry valid and tag matches lookup_addr; cached data
//   fill          : memory read completed; capture fill_addr / fill_data
//   wr_grant      : a write was granted to wr_addr; invalidates on tag match
// -----------------------------------------------------------------------------
module sdram_arb_rdcache
  import sdram_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [DW-1:0] hit_data,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic          wr_grant,
  input  logic [AW-1:0] wr_addr
);

  logic          valid;
  logic          active_q;
  logic [AW-1:0] tag;
  logic [DW-1:0] data;
  logic          invalidate;

  // A fresh download may rewrite anything, and a write to the cached address
  // makes the entry stale.
  assign invalidate = (dl_active && !active_q) || (wr_grant && valid && (wr_addr == tag));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= 1'b0;
      active_q <= 1'b0;
      tag      <= '0;
      data     <= '0;
    end else begin
      active_q <= dl_active;
      if (invalidate) begin
        valid <= 1'b0;
      end else if (fill) begin
        valid <= 1'b1;
        tag   <= fill_addr;
        data  <= fill_data;
      end
    end
  end

  assign hit      = valid && (lookup_addr == tag);
  assign hit_data = data;

endmodule : sdram_arb_rdcache

// File: rtl/sdram_arb.sv
// -----------------------------------------------------------------------------
// sdram_arb
// Arbitrates the single-port SDRAM controller between the download writer
// (ioctl stream) and the VFD frame reader. One pending write and one pending
// read are buffered; writes win, but at most WR_BURST_MAX writes are granted
// in a row while a read waits. Optional single-entry read cache is enabled by
// defining SDRAM_ARB_RDCACHE_EN.
// Ports:
//   clk, reset_n                 : clk_sys, asynchronous active-low reset
//   dl_active                    : download window open (cache invalidate only)
//   dl_wr, dl_addr, dl_data      : write strobe and payload
//   dl_wait                      : write buffer full, requester must hold
//   rd_req, rd_addr              : read strobe and address
//   rd_data, rd_valid, rd_busy   : read result, completion pulse, busy flag
//   mem_addr, mem_din            : controller address / write data
//   mem_we, mem_rd               : controller requests, held until mem_ack
//   mem_ack, mem_dout            : controller completion and read data
// -----------------------------------------------------------------------------
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int WR_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_wait,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_dout
);

  arb_state_t          state, next_state;
  logic                wbuf_full, rbuf_full;
  logic [AW-1:0]       wbuf_addr, rbuf_addr;
  logic [DW-1:0]       wbuf_data;
  logic [STREAK_W-1:0] streak;
  logic                grant_wr, grant_rd;
  logic                wr_ack, rd_ack;
  logic                cache_hit, rd_hit;
  logic [DW-1:0]       cache_data;

  // Acks only count while a request is actually outstanding.
  assign wr_ack = (state == WR) && mem_ack;
  assign rd_ack = (state == RD) && mem_ack;
  assign rd_hit = rd_req && !rbuf_full && cache_hit;

  // NOTE: every signal driven here gets a default first, so no path through the
  // block can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    unique case (state)
      IDLE: begin
        if (wbuf_full && rbuf_full) begin
          if (streak < STREAK_W'(WR_BURST_MAX)) grant_wr = 1'b1;
          else                                   grant_rd = 1'b1;
        end else if (wbuf_full) begin
          grant_wr = 1'b1;
        end else if (rbuf_full) begin
          grant_rd = 1'b1;
        end
        if (grant_wr) next_state = WR;
        if (grant_rd) next_state = RD;
      end
      WR, RD: if (mem_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Request buffers. A buffer freed by this cycle's ack may be refilled by a
  // strobe in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the payload registers are reset too; they are few and it keeps
      // mem_addr/mem_din deterministic after reset.
      wbuf_full <= 1'b0;
      wbuf_addr <= '0;
      wbuf_data <= '0;
      rbuf_full <= 1'b0;
      rbuf_addr <= '0;
    end else begin
      if (wr_ack) wbuf_full <= 1'b0;
      if (dl_wr && (!wbuf_full || wr_ack)) begin
        wbuf_full <= 1'b1;
        wbuf_addr <= dl_addr;
        wbuf_data <= dl_data;
      end
      if (rd_ack) rbuf_full <= 1'b0;
      if (rd_req && (!rbuf_full || rd_ack) && !rd_hit) begin
        rbuf_full <= 1'b1;
        rbuf_addr <= rd_addr;
      end
    end
  end

  // Controller-side outputs, read return and write-streak counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      streak   <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (grant_wr) begin
        mem_we   <= 1'b1;
        mem_addr <= wbuf_addr;
        mem_din  <= wbuf_data;
        // Only writes that overtake a waiting read count toward the bound.
        if (!rbuf_full)        streak <= '0;
        else if (streak != '1) streak <= streak + STREAK_W'(1);
      end
      if (grant_rd) begin
        mem_rd   <= 1'b1;
        mem_addr <= rbuf_addr;
        streak   <= '0;
      end
      if (wr_ack) mem_we <= 1'b0;
      if (rd_ack) begin
        mem_rd   <= 1'b0;
        rd_valid <= 1'b1;
        rd_data  <= mem_dout;
      end else if (rd_hit) begin
        rd_valid <= 1'b1;
        rd_data  <= cache_data;
      end
    end
  end

  assign dl_wait = wbuf_full;
  assign rd_busy = rbuf_full;

`ifdef SDRAM_ARB_RDCACHE_EN
  sdram_arb_rdcache #(
    .AW (AW),
    .DW (DW)
  ) u_rdcache (
    .clk         (clk),
    .reset_n     (reset_n),
    .dl_active   (dl_active),
    .lookup_addr (rd_addr),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .fill        (rd_ack),
    .fill_addr   (mem_addr),
    .fill_data   (mem_dout),
    .wr_grant    (grant_wr),
    .wr_addr     (wbuf_addr)
  );
`else
  // Without the cache every read goes to memory and dl_active has no effect.
  logic unused_dl_active;
  assign unused_dl_active = dl_active;
  assign cache_hit        = 1'b0;
  assign cache_data       = '0;
`endif

endmodule : sdram_arb

// File: tb/tb_sdram_arb.sv
// -----------------------------------------------------------------------------
// tb_sdram_arb
// Self-checking bench for sdram_arb: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model
// compared on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_sdram_arb;

  localparam int AW           = 25;
  localparam int DW           = 8;
  localparam int WR_BURST_MAX = 4;
`ifdef SDRAM_ARB_RDCACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dl_active, dl_wr, rd_req, mem_ack;
  logic [AW-1:0] dl_addr, rd_addr, mem_addr;
  logic [DW-1:0] dl_data, rd_data, mem_din, mem_dout;
  logic          dl_wait, rd_valid, rd_busy, mem_we, mem_rd;

  sdram_arb #(.AW(AW), .DW(DW), .WR_BURST_MAX(WR_BURST_MAX)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .dl_wait   (dl_wait),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_busy   (rd_busy),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .mem_ack   (mem_ack),
    .mem_dout  (mem_dout)
  );

  initial forever #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory controller stand-in ----------------
  int            ack_delay_cfg = -1;   // -1: random 0..3 cycles
  bit            dout_fixed    = 1'b0;
  logic [DW-1:0] dout_cfg      = '0;
  bit            spurious_en   = 1'b0;

  initial begin : env
    int wait_cnt, cur_delay;
    mem_ack  = 1'b0;
    mem_dout = '0;
    wait_cnt = 0;
    cur_delay = 0;
    forever begin
      @(posedge clk); #1;
      mem_dout = dout_fixed ? dout_cfg : DW'($urandom);
      if (!reset_n) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_we || mem_rd) begin
        if (wait_cnt == 0) cur_delay = (ack_delay_cfg < 0) ? int'($urandom_range(3)) : ack_delay_cfg;
        if (wait_cnt >= cur_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = spurious_en && ($urandom_range(7) == 0);
        wait_cnt = 0;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef enum {NO_JOB, WRITE_JOB, READ_JOB} job_t;
  job_t          m_job    = NO_JOB;
  bit            m_wpend  = 0, m_rpend = 0, m_we = 0, m_rd = 0, m_rvalid = 0;
  logic [AW-1:0] m_wa     = '0, m_ra = '0, m_addr = '0;
  logic [DW-1:0] m_wd     = '0, m_din = '0, m_rdata = '0;
  int            wr_run   = 0;   // writes granted while the current read waited
  bit            c_valid  = 0, prev_active = 0;
  logic [AW-1:0] c_tag    = '0;
  logic [DW-1:0] c_data   = '0;

  initial begin : model
    bit   w_was, r_was, w_done, r_done, hit, wr_granted;
    job_t job_was;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_job = NO_JOB; m_wpend = 0; m_rpend = 0; m_we = 0; m_rd = 0; m_rvalid = 0;
        m_wa = '0; m_ra = '0; m_addr = '0; m_wd = '0; m_din = '0; m_rdata = '0;
        wr_run = 0; c_valid = 0; prev_active = 0; c_tag = '0; c_data = '0;
      end else begin
        w_was = m_wpend; r_was = m_rpend; job_was = m_job;
        w_done = mem_ack && (job_was == WRITE_JOB);
        r_done = mem_ack && (job_was == READ_JOB);
        hit = CACHE_ON && rd_req && !r_was && c_valid && (c_tag == rd_addr);
        wr_granted = 0;
        m_rvalid = 0;
        if (w_done) begin m_wpend = 0; m_job = NO_JOB; m_we = 0; end
        if (r_done) begin
          m_rpend = 0; m_job = NO_JOB; m_rd = 0;
          m_rvalid = 1; m_rdata = mem_dout;
        end
        if (hit) begin m_rvalid = 1; m_rdata = c_data; end
        if (job_was == NO_JOB) begin
          if (w_was && (!r_was || wr_run < WR_BURST_MAX)) begin
            m_job = WRITE_JOB; m_we = 1; m_addr = m_wa; m_din = m_wd;
            wr_run = r_was ? wr_run + 1 : 0;
            wr_granted = 1;
          end else if (r_was) begin
            m_job = READ_JOB; m_rd = 1; m_addr = m_ra; wr_run = 0;
          end
        end
        if ((dl_active && !prev_active) || (wr_granted && c_tag == m_wa)) c_valid = 0;
        else if (r_done) begin c_valid = 1; c_tag = m_addr; c_data = mem_dout; end
        prev_active = dl_active;
        if (dl_wr && (!w_was || w_done)) begin m_wpend = 1; m_wa = dl_addr; m_wd = dl_data; end
        if (rd_req && (!r_was || r_done) && !hit) begin m_rpend = 1; m_ra = rd_addr; end
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("dl_wait",    32'(dl_wait),  32'(m_wpend));
      check("rd_busy",    32'(rd_busy),  32'(m_rpend));
      check("mem_we",     32'(mem_we),   32'(m_we));
      check("mem_rd",     32'(mem_rd),   32'(m_rd));
      check("mem_addr",   32'(mem_addr), 32'(m_addr));
      check("mem_din",    32'(mem_din),  32'(m_din));
      check("rd_valid",   32'(rd_valid), 32'(m_rvalid));
      check("rd_data",    32'(rd_data),  32'(m_rdata));
      check("we_rd_excl", 32'(mem_we & mem_rd), 0);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int cnt, rises, grants, wr_pct;
    bit prev, prev_we, prev_busy, seen_rd;
    reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    repeat (3) step();
    check("rst_dl_wait",  32'(dl_wait),  0);
    check("rst_rd_busy",  32'(rd_busy),  0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_mem_we",   32'(mem_we),   0);
    check("rst_mem_rd",   32'(mem_rd),   0);
    check("rst_rd_data",  32'(rd_data),  0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_din",  32'(mem_din),  0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    step();

    // Single write, ack 3 cycles after mem_we rises.
    ack_delay_cfg = 3;
    dl_addr = 25'h4B000; dl_data = 8'hA5; dl_wr = 1'b1;
    step(); dl_wr = 1'b0;
    check("wr_dl_wait_t1", 32'(dl_wait), 1);
    check("wr_mem_we_t1",  32'(mem_we),  0);
    step();
    check("wr_mem_we_t2",  32'(mem_we),  1);
    cnt = 0;
    while (mem_we && cnt < 20) begin
      check("wr_addr_stable", 32'(mem_addr), 32'h4B000);
      check("wr_din_stable",  32'(mem_din),  32'hA5);
      cnt++;
      step();
    end
    check("wr_we_cycles",   cnt, 4);
    check("wr_dl_wait_end", 32'(dl_wait), 0);
    step();

    // Single read returning 0x3C.
    ack_delay_cfg = 1; dout_cfg = 8'h3C; dout_fixed = 1'b1;
    rd_addr = 25'h100; rd_req = 1'b1;
    step(); rd_req = 1'b0;
    check("rd_busy_t1",  32'(rd_busy), 1);
    check("rd_mem_rd_t1", 32'(mem_rd), 0);
    step();
    check("rd_mem_rd_t2", 32'(mem_rd),   1);
    check("rd_mem_addr",  32'(mem_addr), 32'h100);
    cnt = 0;
    while (mem_rd && cnt < 20) begin cnt++; step(); end
    check("rd_rd_cycles", cnt, 2);
    check("rd_valid_a1",  32'(rd_valid), 1);
    check("rd_data_a1",   32'(rd_data),  32'h3C);
    check("rd_busy_a1",   32'(rd_busy),  0);
    step();
    check("rd_valid_a2",  32'(rd_valid), 0);
    dout_fixed = 1'b0;

    // Write guard: second strobe while dl_wait=1 must not overwrite.
    ack_delay_cfg = 2;
    dl_addr = 25'h1234; dl_data = 8'h11; dl_wr = 1'b1;
    step(); dl_addr = 25'h5678; dl_data = 8'h22;
    step(); dl_wr = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_we) begin
        cnt++;
        check("wguard_addr", 32'(mem_addr), 32'h1234);
        check("wguard_din",  32'(mem_din),  32'h11);
      end
      step();
    end
    check("wguard_we_cycles", cnt, 3);
    check("wguard_dl_wait",   32'(dl_wait), 0);

    // Read guard: second strobe while rd_busy=1 must not add a mem_rd.
    rd_addr = 25'h200; rd_req = 1'b1;
    step(); rd_addr = 25'h300;
    step(); rd_req = 1'b0;
    check("rguard_addr", 32'(mem_addr), 32'h200);
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mem_rd && !prev) rises++;
      prev = mem_rd;
      step();
    end
    check("rguard_rd_grants", rises, 1);
    check("rguard_rd_busy",   32'(rd_busy), 0);

    // Starvation bound: continuous writes plus one read.
    ack_delay_cfg = -1;
    grants = 0; seen_rd = 1'b0;
    dl_wr = 1'b1;
    prev_we = mem_we; prev_busy = rd_busy;
    for (int c = 0; c < 80 && !seen_rd; c++) begin
      step();
      dl_addr = 25'h2000 + 25'(c); dl_data = 8'(c);
      rd_req = (c == 3); rd_addr = 25'h777;
      if (mem_we && !prev_we && prev_busy) grants++;
      if (mem_rd) seen_rd = 1'b1;
      prev_we = mem_we; prev_busy = rd_busy;
    end
    dl_wr = 1'b0; rd_req = 1'b0;
    check("starve_rd_granted", 32'(seen_rd), 1);
    check("starve_wr_le_max",  32'(grants <= WR_BURST_MAX), 1);
    repeat (12) step();

    // Reset while a read is in flight.
    ack_delay_cfg = 20;
    rd_addr = 25'h400; rd_req = 1'b1;
    step(); rd_req = 1'b0;
    step();
    check("rstmid_mem_rd_before", 32'(mem_rd), 1);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_mem_rd_async",  32'(mem_rd),  0);
    check("rstmid_rd_busy_async", 32'(rd_busy), 0);
    step(); step();
    reset_n = 1'b1; ack_delay_cfg = -1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_rd || rd_valid || rd_busy) cnt++;
    end
    check("rstmid_quiet_after", cnt, 0);

`ifdef SDRAM_ARB_RDCACHE_EN
    // Cache: miss fills, repeat hits at t+1, write to tag forces memory.
    ack_delay_cfg = 1; dout_cfg = 8'h5A; dout_fixed = 1'b1;
    rd_addr = 25'h100; rd_req = 1'b1; step(); rd_req = 1'b0;
    repeat (6) step();
    rd_req = 1'b1; step(); rd_req = 1'b0;
    check("cache_hit_valid", 32'(rd_valid), 1);
    check("cache_hit_data",  32'(rd_data),  32'h5A);
    check("cache_hit_busy",  32'(rd_busy),  0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin if (mem_rd) cnt++; step(); end
    check("cache_hit_no_mem_rd", cnt, 0);
    dl_addr = 25'h100; dl_data = 8'h77; dl_wr = 1'b1; step(); dl_wr = 1'b0;
    repeat (6) step();
    rd_req = 1'b1; step(); rd_req = 1'b0;
    step();
    check("cache_inval_mem_rd", 32'(mem_rd), 1);
    repeat (6) step();
    dout_fixed = 1'b0;
`endif

    // Randomized traffic; the every-cycle compare does the checking.
    spurious_en = 1'b1; ack_delay_cfg = -1;
    for (int i = 0; i < 2500; i++) begin
      step();
      wr_pct  = ((i / 500) % 2 == 1) ? 80 : 25;
      dl_wr   = ($urandom_range(99) < wr_pct);
      dl_addr = $urandom_range(1) ? 25'($urandom_range(15)) : 25'($urandom);
      dl_data = DW'($urandom);
      rd_req  = ($urandom_range(99) < 30);
      rd_addr = $urandom_range(1) ? 25'($urandom_range(15)) : 25'($urandom);
      if ($urandom_range(49) == 0) dl_active = ~dl_active;
    end
    dl_wr = 1'b0; rd_req = 1'b0; spurious_en = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_sdram_arb
